gpio_in_filter: RTL and testbench
=================================

// Module: gpio_in_filter
// PURPOSE
//  Input conditioning stage directly upstream of the GPIO controller's gpio_data_i.
//  Per pin: synchronises the asynchronous pad input, then optionally debounces it
//  with a programmable stable-time counter.
//  Outputs the filtered level plus one-cycle rise/fall pulses for edge-triggered IRQ logic.
//  Clock/reset: one clock; reset is asynchronous and active-high.
// PARAMETERS
//  GPIO_NUM     2     number of pins
//  SYNC_STAGES  2     synchroniser flops per pin, legal range >= 2
//  CNT_W        16    width of the debounce counter and threshold
//  RST_VAL      '0    [GPIO_NUM-1:0] reset level of sync chain and data_o
// PORTS
//  clk_i              in   1         clock
//  rst_i              in   1         async reset, active-high
//  pad_i              in   GPIO_NUM  raw pad inputs, asynchronous to clk_i
//  filter_en_i        in   GPIO_NUM  per-pin debounce enable (quasi-static)
//  debounce_cycles_i  in   CNT_W     stable-time threshold N, shared by all pins
//  data_o             out  GPIO_NUM  filtered level -> controller gpio_data_i
//  rise_o             out  GPIO_NUM  1-cycle pulse on data_o 0->1
//  fall_o             out  GPIO_NUM  1-cycle pulse on data_o 1->0
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - sync chain and data_o = RST_VAL
//   - counters = 0; rise_o/fall_o = 0
//   - no pulses on the first cycle after release
//  Sync: s = last stage of a SYNC_STAGES flop chain; no logic between chain flops.
//  Per pin, each posedge; thr = filter_en_i[k] ? debounce_cycles_i : 0:
//   - s == data_o: cnt <= 0; data_o holds.
//   - s != data_o, cnt >= thr: data_o <= s; cnt <= 0; pulse on rise_o or fall_o.
//   - s != data_o, cnt <  thr: cnt <= cnt + 1. cnt never wraps: it stays <= thr
//     while thr is constant, and is cleared on update.
//  Latency:
//   - pad change in the setup window of edge 0: s valid after edge SYNC_STAGES;
//     data_o updates at edge SYNC_STAGES+1+thr.
//   - Bypass (filter_en=0) and N=0 are identical: SYNC_STAGES+1 cycles.
//  Glitch rejection: any return of s to data_o before cnt reaches thr clears cnt.
//   Pulses narrower than thr+1 synced cycles never reach data_o.
//  Threshold lowered mid-count (cnt >= new thr): update on the next differing cycle (>= compare).
//  Filter disabled mid-count: the next differing cycle updates immediately (thr=0).
//  rise_o/fall_o are registered alongside data_o:
//   - high exactly in the cycle data_o first shows the new value;
//   - never both high for one pin; independent across pins.
//  Reset mid-count: all state returns to reset values; the pending change is lost.
//  No bus interface; config inputs are driven by the controller's registers.
// TESTING
//  1. Reset: rst_i=1 with pad_i=2'b11, RST_VAL=0 -> data_o=0, rise_o=fall_o=0.
//     Release rst_i -> data_o=2'b11 at edge 3 with rise_o=2'b11 for exactly 1 cycle.
//  2. Bypass: filter_en=0, pad[0] 0->1 before edge 0 -> data_o[0]=1 and rise_o[0]=1 at edge 3.
//     fall_o stays 0.
//  3. Debounce: filter_en=1, N=5, pad[1] 1->0 held -> data_o[1] falls at edge 8.
//     fall_o[1] is a 1-cycle pulse at edge 8.
//  4. Glitch: N=5, pad[0] high for 4 cycles then low -> data_o[0] never changes, no pulses.
//     A 6-cycle pulse is accepted.
//  5. Threshold change: N=10, after 3 differing cycles N:=1 -> data_o updates on the next edge.
//  6. Reset mid-count: N=5, pad toggled, rst_i pulsed at count 3 -> data_o=RST_VAL, no pulse.
//     Filtering restarts from 0 after release.

Source files
------------

// File: rtl/gpio_in_filter.sv
// Per-pin GPIO input conditioning: pad synchroniser, optional stable-time debounce,
// and registered one-cycle rise/fall pulses for edge-triggered interrupt logic.

module gpio_in_filter_lane #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 16,
    parameter logic RST_BIT     = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pad_i,
    input  logic             filter_en_i,
    input  logic [CNT_W-1:0] debounce_cycles_i,
    output logic             data_o,
    output logic             rise_o,
    output logic             fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       thr;
    logic                   s;

    // Plain flop chain: nothing may sit between stages or metastability can leak through.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= {SYNC_STAGES{RST_BIT}};
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end

    assign s   = sync_q[SYNC_STAGES-1];
    assign thr = filter_en_i ? debounce_cycles_i : '0;

    // cnt only increments while below thr and clears on any match or update, so it never wraps;
    // the >= compare also handles a threshold lowered mid-count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= RST_BIT;
            cnt_q  <= '0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else if (s == data_o) begin
            cnt_q  <= '0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else if (cnt_q >= thr) begin
            data_o <= s;
            cnt_q  <= '0;
            rise_o <= s;
            fall_o <= ~s;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end
    end
endmodule

module gpio_in_filter #(
    parameter int                  GPIO_NUM    = 2,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  CNT_W       = 16,
    parameter logic [GPIO_NUM-1:0] RST_VAL     = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [GPIO_NUM-1:0] pad_i,
    input  logic [GPIO_NUM-1:0] filter_en_i,
    input  logic [CNT_W-1:0]    debounce_cycles_i,
    output logic [GPIO_NUM-1:0] data_o,
    output logic [GPIO_NUM-1:0] rise_o,
    output logic [GPIO_NUM-1:0] fall_o
);
    for (genvar k = 0; k < GPIO_NUM; k++) begin : g_lane
        gpio_in_filter_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .RST_BIT     (RST_VAL[k])
        ) u_lane (
            .clk_i             (clk_i),
            .rst_i             (rst_i),
            .pad_i             (pad_i[k]),
            .filter_en_i       (filter_en_i[k]),
            .debounce_cycles_i (debounce_cycles_i),
            .data_o            (data_o[k]),
            .rise_o            (rise_o[k]),
            .fall_o            (fall_o[k])
        );
    end
endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed and random checks of gpio_in_filter against a cycle-level reference model
// built from the stable-time rule: a level is accepted after thr+1 consecutive differing cycles.

module tb_gpio_in_filter;
    localparam int         G = 2;
    localparam int         S = 2;
    localparam int         W = 16;
    localparam logic [1:0] RV = 2'b00;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [G-1:0] pad_i;
    logic [G-1:0] filter_en_i;
    logic [W-1:0] debounce_cycles_i;
    logic [G-1:0] data_o, rise_o, fall_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [G-1:0] pq[$];          // pad samples, newest first
    logic [G-1:0] m_data, m_rise, m_fall;
    int           m_run[G];       // consecutive edges on which the synced level differed

    gpio_in_filter #(.GPIO_NUM(G), .SYNC_STAGES(S), .CNT_W(W), .RST_VAL(RV)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .pad_i             (pad_i),
        .filter_en_i       (filter_en_i),
        .debounce_cycles_i (debounce_cycles_i),
        .data_o            (data_o),
        .rise_o            (rise_o),
        .fall_o            (fall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [G-1:0] obs, input logic [G-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        for (int i = 0; i < S; i++) pq.push_front(RV);
        m_data = RV;
        m_rise = '0;
        m_fall = '0;
        for (int k = 0; k < G; k++) m_run[k] = 0;
    endtask

    // Synced level seen by the filter at an edge is the pad sampled S edges earlier.
    task automatic model_edge();
        logic [G-1:0] s;
        int thr;
        s = pq[S-1];
        pq.push_front(pad_i);
        void'(pq.pop_back());
        for (int k = 0; k < G; k++) begin
            thr = filter_en_i[k] ? int'(debounce_cycles_i) : 0;
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            if (s[k] == m_data[k]) m_run[k] = 0;
            else if (m_run[k] >= thr) begin
                m_data[k] = s[k];
                m_run[k]  = 0;
                m_rise[k] = s[k];
                m_fall[k] = ~s[k];
            end else m_run[k]++;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_i) model_reset();
        else       model_edge();
        #1;
        chk("model_data", data_o, m_data);
        chk("model_rise", rise_o, m_rise);
        chk("model_fall", fall_o, m_fall);
    endtask

    initial begin
        logic [G-1:0] saw_rise;
        // 1: reset with pads high, release, both pins rise on the third edge
        rst_i = 1'b1; pad_i = 2'b11; filter_en_i = 2'b00; debounce_cycles_i = '0;
        model_reset();
        #2;
        chk("rst_data", data_o, 2'b00);
        chk("rst_rise", rise_o, 2'b00);
        chk("rst_fall", fall_o, 2'b00);
        tick(); tick();
        rst_i = 1'b0;
        tick(); chk("rel_e1_data", data_o, 2'b00); chk("rel_e1_rise", rise_o, 2'b00);
        tick(); chk("rel_e2_data", data_o, 2'b00);
        tick(); chk("rel_e3_data", data_o, 2'b11); chk("rel_e3_rise", rise_o, 2'b11);
        tick(); chk("rel_e4_rise", rise_o, 2'b00);

        // 2: bypass, pad[0] 1->0 then 0->1
        pad_i = 2'b10;
        repeat (4) tick();
        chk("byp_low", data_o, 2'b10);
        pad_i = 2'b11;
        tick(); tick(); chk("byp_e2_data", data_o, 2'b10);
        tick(); chk("byp_e3_data", data_o, 2'b11); chk("byp_e3_rise", rise_o, 2'b01);
        chk("byp_e3_fall", fall_o, 2'b00);

        // 3: debounce N=5, pad[1] falls at edge 8
        filter_en_i = 2'b11; debounce_cycles_i = 16'd5; pad_i = 2'b01;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("deb_data", data_o, (i >= 8) ? 2'b01 : 2'b11);
            chk("deb_fall", fall_o, (i == 8) ? 2'b10 : 2'b00);
        end

        // 4: glitch rejection then acceptance of a 6-cycle pulse
        pad_i = 2'b00;
        repeat (10) tick();
        chk("gl_base", data_o, 2'b00);
        pad_i = 2'b01;
        repeat (4) tick();
        pad_i = 2'b00;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("gl4_data", data_o, 2'b00);
            chk("gl4_rise", rise_o, 2'b00);
        end
        pad_i = 2'b01;
        saw_rise = '0;
        for (int i = 0; i < 6; i++) begin tick(); saw_rise |= rise_o; end
        pad_i = 2'b00;
        for (int i = 0; i < 14; i++) begin tick(); saw_rise |= rise_o; end
        chk("gl6_rise_seen", saw_rise, 2'b01);
        chk("gl6_back_low", data_o, 2'b00);

        // 5: N=10, lowered to 1 after 3 differing cycles
        debounce_cycles_i = 16'd10; pad_i = 2'b10;
        for (int i = 0; i < 5; i++) begin tick(); chk("thr_hold", data_o, 2'b00); end
        debounce_cycles_i = 16'd1;
        tick(); chk("thr_upd_data", data_o, 2'b10); chk("thr_upd_rise", rise_o, 2'b10);

        // 6: reset at count 3 drops the pending change, filtering restarts from 0
        debounce_cycles_i = 16'd5; pad_i = 2'b11;
        repeat (5) tick();
        #2; rst_i = 1'b1; model_reset();
        #1;
        chk("mid_rst_data", data_o, RV);
        chk("mid_rst_rise", rise_o, 2'b00);
        chk("mid_rst_fall", fall_o, 2'b00);
        tick(); tick();
        rst_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("restart_data", data_o, (i >= 8) ? 2'b11 : 2'b00);
            chk("restart_rise", rise_o, (i == 8) ? 2'b11 : 2'b00);
        end

        // 7: random pads, thresholds and enables against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) pad_i = G'($urandom);
            if ($urandom_range(0, 39) == 0) debounce_cycles_i = W'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) filter_en_i = G'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2; rst_i = 1'b1; model_reset();
                tick();
                rst_i = 1'b0;
            end
            tick();
            if ((rise_o & fall_o) != '0) begin
                checks++;
                errors++;
                $error("FAIL both_pulses rise=%b fall=%b", rise_o, fall_o);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
